// File: rtl/conv_window_sched_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg: shared constants and types for the convolution front end.
//   IMG_W/IMG_H  image size in pixels
//   K            kernel size (window is K x K taps)
//   STRIDE/PAD   output step and zero border width
//   pixel_t      24-bit {R,G,B} pixel
//   win_t        NTAP packed pixels; tap t occupies bits [24t+23:24t]
//   sched_state_e  window scheduler FSM states
// ---------------------------------------------------------------------------
package cnn_pkg;

   localparam int IMG_W  = 32;
   localparam int IMG_H  = 32;
   localparam int K      = 3;
   localparam int STRIDE = 1;
   localparam int PAD    = 1;

   localparam int OUT_W  = (IMG_W + 2*PAD - K) / STRIDE + 1;
   localparam int OUT_H  = (IMG_H + 2*PAD - K) / STRIDE + 1;
   localparam int NTAP   = K * K;

   // Port widths of the buffer address and the window position.
   localparam int ADDR_W = 12;
   localparam int POS_W  = 5;
   localparam int TAP_W  = $clog2(NTAP);

   typedef logic [23:0]       pixel_t;
   typedef pixel_t [NTAP-1:0] win_t;
   typedef logic [POS_W-1:0]  pos_t;
   typedef logic [TAP_W-1:0]  tap_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BUF,
      FETCH,
      PRESENT,
      DONE
   } sched_state_e;

endpackage

// File: rtl/conv_window_sched_if.sv
// ---------------------------------------------------------------------------
// conv_window_sched_if: window handshake between the scheduler and the
// first convolution layer.
//   win_valid  window available (master -> slave)
//   win_ready  consumer accepts window (slave -> master)
//   win_data   NTAP taps, row-major (ky,kx)
//   win_row    output row oy of the presented window
//   win_col    output column ox of the presented window
// ---------------------------------------------------------------------------
interface conv_window_sched_if;
   import cnn_pkg::*;

   logic win_valid;
   logic win_ready;
   win_t win_data;
   pos_t win_row;
   pos_t win_col;

   modport master (
      output win_valid,
      output win_data,
      output win_row,
      output win_col,
      input  win_ready
   );

   modport slave (
      input  win_valid,
      input  win_data,
      input  win_row,
      input  win_col,
      output win_ready
   );

endinterface

// File: rtl/win_addr_gen.sv
// ---------------------------------------------------------------------------
// win_addr_gen: maps (output position, tap index) to an image buffer
// address. Purely combinational.
//   i_ox, i_oy    output column / row
//   i_tap         tap index t, ky = t / K, kx = t % K
//   o_raddr       y*IMG_W + x when in bounds, else 0
//   o_in_bounds   1 when the tap lands inside the image, 0 in the pad
// ---------------------------------------------------------------------------
module win_addr_gen
   import cnn_pkg::*;
(
   input  pos_t              i_ox,
   input  pos_t              i_oy,
   input  tap_t              i_tap,
   output logic [ADDR_W-1:0] o_raddr,
   output logic              o_in_bounds
);

   // Signed 32-bit coordinates so the padded border goes negative cleanly.
   int w_ky;
   int w_kx;
   int w_y;
   int w_x;

   // NOTE: combinational blocks use blocking '=' so each line sees the
   // values computed above it; clocked blocks use '<=' exclusively.
   always_comb begin
      w_ky        = int'(i_tap) / K;
      w_kx        = int'(i_tap) % K;
      w_y         = int'(i_oy) * STRIDE + w_ky - PAD;
      w_x         = int'(i_ox) * STRIDE + w_kx - PAD;
      o_in_bounds = (w_y >= 0) && (w_y < IMG_H) && (w_x >= 0) && (w_x < IMG_W);
      // Pad taps drive address 0 so raddr never leaves the buffer.
      o_raddr     = o_in_bounds ? ADDR_W'(w_y * IMG_W + w_x) : '0;
   end

endmodule

// File: rtl/conv_window_sched.sv
// ---------------------------------------------------------------------------
// conv_window_sched: scans the loaded image once per start pulse, fetching
// one K x K zero-padded window per output position over the buffer's
// combinational read port and presenting it on a valid/ready handshake.
//   clk        system clock
//   rst_n      synchronous reset, ACTIVE HIGH (1 = reset)
//   start      one-cycle scan request, ignored while busy
//   buf_ready  image buffer fully loaded
//   raddr      registered pixel address, matches the tap captured this cycle
//   rdata      {R,G,B} at raddr, same-cycle return
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last window is accepted
//   win        window handshake (master side)
// ---------------------------------------------------------------------------
module conv_window_sched
   import cnn_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              buf_ready,
   output logic [ADDR_W-1:0] raddr,
   input  pixel_t            rdata,
   output logic              busy,
   output logic              done,
   conv_window_sched_if.master win
);

   sched_state_e      r_state;
   tap_t              r_tap;
   pos_t              r_ox;
   pos_t              r_oy;
   logic [ADDR_W-1:0] r_raddr;
   logic              r_inb;
   win_t              r_win;
   logic              r_win_valid;
   logic              r_busy;
   logic              r_done;

   // Coordinates of the tap to be fetched in the cycle after this edge.
   tap_t              w_nx_tap;
   pos_t              w_nx_ox;
   pos_t              w_nx_oy;
   logic [ADDR_W-1:0] w_gen_raddr;
   logic              w_gen_inb;
   logic              w_last_pos;

   assign w_last_pos = (r_ox == POS_W'(OUT_W - 1)) && (r_oy == POS_W'(OUT_H - 1));

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      w_nx_tap = r_tap + TAP_W'(1);
      w_nx_ox  = r_ox;
      w_nx_oy  = r_oy;
      case (r_state)
         FETCH: ;
         PRESENT: begin
            w_nx_tap = '0;
            if (r_ox == POS_W'(OUT_W - 1)) begin
               w_nx_ox = '0;
               w_nx_oy = r_oy + POS_W'(1);
            end else begin
               w_nx_ox = r_ox + POS_W'(1);
            end
         end
         default: begin
            w_nx_tap = '0;
            w_nx_ox  = '0;
            w_nx_oy  = '0;
         end
      endcase
   end

   // The address is computed one cycle ahead and registered, so the value
   // on raddr during a FETCH cycle belongs to the tap captured at its end.
   win_addr_gen u_addr_gen (
      .i_ox        (w_nx_ox),
      .i_oy        (w_nx_oy),
      .i_tap       (w_nx_tap),
      .o_raddr     (w_gen_raddr),
      .o_in_bounds (w_gen_inb)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state     <= IDLE;
         r_tap       <= '0;
         r_ox        <= '0;
         r_oy        <= '0;
         r_raddr     <= '0;
         r_inb       <= 1'b0;
         // NOTE: the window register is reset too; it is a small flop
         // array, and clearing it means no partial window survives a reset.
         r_win       <= '0;
         r_win_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  if (buf_ready) begin
                     r_state <= FETCH;
                     r_tap   <= '0;
                     r_raddr <= w_gen_raddr;
                     r_inb   <= w_gen_inb;
                  end else begin
                     r_state <= WAIT_BUF;
                  end
               end
            end

            WAIT_BUF: begin
               if (buf_ready) begin
                  r_state <= FETCH;
                  r_tap   <= '0;
                  r_raddr <= w_gen_raddr;
                  r_inb   <= w_gen_inb;
               end
            end

            FETCH: begin
               r_win[r_tap] <= r_inb ? rdata : '0;
               if (r_tap == TAP_W'(NTAP - 1)) begin
                  r_state     <= PRESENT;
                  r_win_valid <= 1'b1;
                  r_raddr     <= '0;
                  r_inb       <= 1'b0;
               end else begin
                  r_tap   <= w_nx_tap;
                  r_raddr <= w_gen_raddr;
                  r_inb   <= w_gen_inb;
               end
            end

            PRESENT: begin
               if (win.win_ready) begin
                  r_win_valid <= 1'b0;
                  if (w_last_pos) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= FETCH;
                     r_ox    <= w_nx_ox;
                     r_oy    <= w_nx_oy;
                     r_tap   <= '0;
                     r_raddr <= w_gen_raddr;
                     r_inb   <= w_gen_inb;
                  end
               end
            end

            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_ox    <= '0;
               r_oy    <= '0;
               r_tap   <= '0;
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign raddr         = r_raddr;
   assign busy          = r_busy;
   assign done          = r_done;
   assign win.win_valid = r_win_valid;
   assign win.win_data  = r_win;
   assign win.win_row   = r_oy;
   assign win.win_col   = r_ox;

endmodule
